dcache_wport_arbiter: RTL and testbench

// - Shares the single D$ write request port among NR_REQ store-side requesters
//   (store-buffer commit, RM trace logger, debug/CSR writer, ...).
// - Round-robin with per-requester starvation escalation.
// - Locks the port to the winner until its request is granted (data_gnt).
// - Sits between the store unit's request producers and the cache subsystem.

---
 rtl/ariane_pkg.sv | 29 ++
 rtl/dcache_wport_arbiter_rr_prio_pick.sv | 32 +++
 rtl/dcache_wport_arbiter.sv | 146 ++++++++++++++
 tb/tb_dcache_wport_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared D$ request/response types and write-port arbiter enums
package ariane_pkg;

    localparam int DCACHE_WPORT_NR_REQ = 3;

    typedef struct packed {
        logic [11:0] address_index;
        logic [19:0] address_tag;
        logic [31:0] data_wdata;
        logic        data_req;
        logic        data_we;
        logic [3:0]  data_be;
        logic [1:0]  data_size;
        logic        kill_req;
        logic        tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [31:0] data_rdata;
    } dcache_req_o_t;

    typedef enum logic {
        WARB_IDLE,
        WARB_LOCKED
    } wport_arb_state_e;

endpackage

// File: rtl/dcache_wport_arbiter_rr_prio_pick.sv
// rtl/dcache_wport_arbiter_rr_prio_pick.sv - first set bit of a mask at/after a rotating pointer
module rr_prio_pick #(
    parameter int NR_REQ = 3
) (
    input  logic [NR_REQ-1:0]         mask,
    input  logic [$clog2(NR_REQ)-1:0] ptr,
    output logic                      valid,
    output logic [$clog2(NR_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NR_REQ);

    int pos;

    // Walk offsets from ptr, wrapping NR_REQ-1 -> 0; the first hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = 0; i < NR_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NR_REQ) begin
                pos = pos - NR_REQ;
            end
            if (!valid && mask[IDX_W'(pos)]) begin
                valid = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/dcache_wport_arbiter.sv
// rtl/dcache_wport_arbiter.sv - round-robin D$ write-port arbiter with starvation escalation and grant lock
module dcache_wport_arbiter
    import ariane_pkg::*;
#(
    parameter int NR_REQ   = DCACHE_WPORT_NR_REQ,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [NR_REQ-1:0]   req_i,
    input  dcache_req_i_t       req_data_i [NR_REQ],
    output logic [NR_REQ-1:0]   gnt_o,
    output logic                busy_o,
    output logic [NR_REQ-1:0]   starve_o,
    input  dcache_req_o_t       req_port_i,
    output dcache_req_i_t       req_port_o
);

    localparam int IDX_W = $clog2(NR_REQ);

    wport_arb_state_e  state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
    logic [WAIT_W-1:0] wait_cnt_q [NR_REQ];
    logic [NR_REQ-1:0] starve;
    logic              esc_valid, raw_valid;
    logic [IDX_W-1:0]  esc_idx, raw_idx, win_idx, sel_idx;
    logic              drive, active;
    logic              unused_rsp;

    assign unused_rsp = ^{req_port_i.data_rvalid, req_port_i.data_rdata};

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] i);
        return (int'(i) == NR_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        for (int k = 0; k < NR_REQ; k++) begin
            starve[k] = (wait_cnt_q[k] == WAIT_W'(MAX_WAIT));
        end
    end

    assign starve_o = starve;

    rr_prio_pick #(.NR_REQ(NR_REQ)) u_pick_esc (
        .mask  (starve & req_i),
        .ptr   (rr_ptr_q),
        .valid (esc_valid),
        .idx   (esc_idx)
    );

    rr_prio_pick #(.NR_REQ(NR_REQ)) u_pick_raw (
        .mask  (req_i),
        .ptr   (rr_ptr_q),
        .valid (raw_valid),
        .idx   (raw_idx)
    );

    assign win_idx = esc_valid ? esc_idx : raw_idx;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        sel_idx    = win_idx;
        drive      = 1'b0;
        active     = 1'b0;
        gnt_o      = '0;
        busy_o     = 1'b0;
        unique case (state_q)
            WARB_IDLE: begin
                drive = raw_valid;
                // A flush suppresses both the same-cycle grant and the lock.
                if (raw_valid && !flush_i) begin
                    active = 1'b1;
                    if (req_port_i.data_gnt) begin
                        gnt_o[win_idx] = 1'b1;
                        rr_ptr_d       = rr_next(win_idx);
                    end else begin
                        state_d    = WARB_LOCKED;
                        lock_idx_d = win_idx;
                    end
                end
            end
            WARB_LOCKED: begin
                sel_idx = lock_idx_q;
                drive   = 1'b1;
                busy_o  = 1'b1;
                if (!req_i[lock_idx_q]) begin
                    state_d = WARB_IDLE;
                end else begin
                    active = 1'b1;
                    if (req_port_i.data_gnt) begin
                        gnt_o[lock_idx_q] = 1'b1;
                        rr_ptr_d          = rr_next(lock_idx_q);
                        state_d           = WARB_IDLE;
                    end
                end
            end
            default: state_d = WARB_IDLE;
        endcase
        if (rst_i) begin
            drive  = 1'b0;
            active = 1'b0;
            gnt_o  = '0;
            busy_o = 1'b0;
        end
    end

    always_comb begin
        req_port_o = '0;
        if (drive) begin
            req_port_o          = req_data_i[sel_idx];
            req_port_o.data_req = active;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= WARB_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            for (int k = 0; k < NR_REQ; k++) begin
                wait_cnt_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            for (int k = 0; k < NR_REQ; k++) begin
                if (gnt_o[k] || !req_i[k]) begin
                    wait_cnt_q[k] <= '0;
                end else if (wait_cnt_q[k] != WAIT_W'(MAX_WAIT)) begin
                    wait_cnt_q[k] <= wait_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // A locked requester must hold its request until granted.
    lock_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == WARB_LOCKED) |-> req_i[lock_idx_q]);

endmodule

// File: tb/tb_dcache_wport_arbiter.sv
// tb/tb_dcache_wport_arbiter.sv - directed and randomized checks of the D$ write-port arbiter
module tb_dcache_wport_arbiter;
    import ariane_pkg::*;

    localparam int N  = 3;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [N-1:0]  req;
    dcache_req_i_t req_data [N];
    logic [N-1:0]  gnt;
    logic          busy;
    logic [N-1:0]  starve;
    dcache_req_o_t port_in;
    dcache_req_i_t port_out;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_locked;
    int m_owner;
    int m_rr;
    int m_wait [N];

    always #5 clk = ~clk;

    dcache_wport_arbiter #(.NR_REQ(N), .MAX_WAIT(MW), .WAIT_W(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .req_i      (req),
        .req_data_i (req_data),
        .gnt_o      (gnt),
        .busy_o     (busy),
        .starve_o   (starve),
        .req_port_i (port_in),
        .req_port_o (port_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic dcache_req_i_t mk_payload();
        dcache_req_i_t p;
        p.address_index = 12'($urandom);
        p.address_tag   = 20'($urandom);
        p.data_wdata    = $urandom;
        p.data_req      = 1'b1;
        p.data_we       = 1'b1;
        p.data_be       = 4'($urandom);
        p.data_size     = 2'($urandom);
        p.kill_req      = 1'($urandom);
        p.tag_valid     = 1'b1;
        return p;
    endfunction

    function automatic int model_pick(logic [N-1:0] r);
        for (int off = 0; off < N; off++) begin
            int k = (m_rr + off) % N;
            if (r[k] && m_wait[k] == MW) return k;
        end
        for (int off = 0; off < N; off++) begin
            int k = (m_rr + off) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        flush   = 1'b0;
        port_in = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) req_data[k] = mk_payload();
        rst     = 1'b1;
        flush   = 1'b0;
        req     = 3'b111;
        port_in = '0;
        port_in.data_gnt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (port_out.data_req !== 1'b0 || gnt !== 3'b000 || busy !== 1'b0 || starve !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold c%0d: data_req=%b gnt=%b busy=%b starve=%b required 0/000/0/000",
                         c, port_out.data_req, gnt, busy, starve);
            end
            tick();
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            logic [N-1:0] e;
            e = 3'b001 << (c % N);
            #2;
            checks++;
            if (gnt !== e || port_out !== req_data[c % N]) begin
                errors++;
                $display("FAIL rr_grant c%0d: gnt=%b required %b", c, gnt, e);
            end
            tick();
        end
        req = '0;
        port_in = '0;
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        for (int k = 0; k < N; k++) req_data[k] = mk_payload();
        req = 3'b011;
        for (int c = 0; c <= 5; c++) begin
            port_in.data_gnt = (c == 5);
            #2;
            checks++;
            if (busy !== (c >= 1) || gnt !== ((c == 5) ? 3'b001 : 3'b000) || port_out !== req_data[0]) begin
                errors++;
                $display("FAIL lock c%0d: busy=%b gnt=%b port=%h required busy=%b payload %h",
                         c, busy, gnt, port_out, (c >= 1), req_data[0]);
            end
            tick();
        end
        req = 3'b010;
        port_in.data_gnt = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || port_out !== req_data[1]) begin
            errors++;
            $display("FAIL lock_release: busy=%b port=%h required 0 and %h", busy, port_out, req_data[1]);
        end
        tick();
        port_in.data_gnt = 1'b1;
        tick();
        req = '0;
        port_in = '0;
    endtask

    task automatic test_starve();
        do_reset();
        for (int k = 0; k < N; k++) req_data[k] = mk_payload();
        req = 3'b101;
        for (int c = 0; c <= 15; c++) begin
            if (c == 15) req = 3'b111;
            #2;
            checks++;
            if (starve !== ((c >= 15) ? 3'b101 : 3'b000) || gnt !== 3'b000) begin
                errors++;
                $display("FAIL starve c%0d: starve=%b gnt=%b required %b 000",
                         c, starve, gnt, (c >= 15) ? 3'b101 : 3'b000);
            end
            tick();
        end
        port_in.data_gnt = 1'b1;
        #2;
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL starve_release: gnt=%b required 001", gnt);
        end
        tick();
        req = 3'b110;
        #2;
        checks++;
        if (gnt !== 3'b100 || port_out !== req_data[2] || starve !== 3'b100) begin
            errors++;
            $display("FAIL starve_escalate: gnt=%b starve=%b required 100 100", gnt, starve);
        end
        tick();
        req = '0;
        port_in = '0;
    endtask

    task automatic test_flush_idle();
        do_reset();
        for (int k = 0; k < N; k++) req_data[k] = mk_payload();
        req   = 3'b100;
        flush = 1'b1;
        port_in.data_gnt = 1'b1;
        #2;
        checks++;
        if (gnt !== 3'b000 || port_out.data_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: gnt=%b data_req=%b busy=%b required 000 0 0",
                     gnt, port_out.data_req, busy);
        end
        tick();
        flush = 1'b0;
        port_in.data_gnt = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || port_out.data_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_no_lock: busy=%b data_req=%b required 0 1", busy, port_out.data_req);
        end
        tick();
        port_in.data_gnt = 1'b1;
        #2;
        checks++;
        if (gnt !== 3'b100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: gnt=%b busy=%b required 100 1", gnt, busy);
        end
        tick();
        req = '0;
        port_in = '0;
    endtask

    task automatic test_flush_locked();
        do_reset();
        for (int k = 0; k < N; k++) req_data[k] = mk_payload();
        req_data[1].kill_req = 1'b1;
        req = 3'b010;
        tick();
        flush = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b1 || port_out.data_req !== 1'b1 || port_out.kill_req !== 1'b1 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL flush_locked: busy=%b data_req=%b kill=%b gnt=%b required 1 1 1 000",
                     busy, port_out.data_req, port_out.kill_req, gnt);
        end
        tick();
        port_in.data_gnt = 1'b1;
        #2;
        checks++;
        if (gnt !== 3'b010) begin
            errors++;
            $display("FAIL flush_locked_gnt: gnt=%b required 010", gnt);
        end
        tick();
        flush = 1'b0;
        req = '0;
        port_in = '0;
    endtask

    task automatic test_reset_locked();
        do_reset();
        for (int k = 0; k < N; k++) req_data[k] = mk_payload();
        req = 3'b001;
        port_in.data_gnt = 1'b1;
        tick();
        req = 3'b010;
        port_in.data_gnt = 1'b0;
        tick();
        #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_lock: busy=%b required 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (port_out !== '0 || busy !== 1'b0 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_lock: port=%h busy=%b gnt=%b required 0 0 000", port_out, busy, gnt);
        end
        tick();
        rst = 1'b0;
        req = 3'b011;
        port_in.data_gnt = 1'b1;
        #2;
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_gnt: gnt=%b required 001", gnt);
        end
        tick();
        req = '0;
        port_in = '0;
    endtask

    task automatic test_random();
        logic [N-1:0]  pend;
        logic [N-1:0]  exp_gnt, exp_starve;
        logic          exp_busy;
        dcache_req_i_t exp_port;
        int            w;
        do_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        for (int k = 0; k < N; k++) m_wait[k] = 0;
        pend = '0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(1, 0) == 1) begin
                    pend[k]     = 1'b1;
                    req_data[k] = mk_payload();
                end
            end
            req   = pend;
            flush = ($urandom_range(9, 0) == 0);
            port_in.data_gnt = ($urandom_range((c < 300) ? 3 : 11, 0) == 0);

            exp_gnt  = '0;
            exp_busy = 1'b0;
            exp_port = '0;
            for (int k = 0; k < N; k++) exp_starve[k] = (m_wait[k] == MW);
            if (m_locked) begin
                w        = m_owner;
                exp_busy = 1'b1;
                exp_port = req_data[w];
                if (port_in.data_gnt) exp_gnt[w] = 1'b1;
            end else begin
                w = model_pick(req);
                if (w >= 0) begin
                    exp_port          = req_data[w];
                    exp_port.data_req = !flush;
                    if (!flush && port_in.data_gnt) exp_gnt[w] = 1'b1;
                end
            end

            #2;
            checks++;
            if (gnt !== exp_gnt || busy !== exp_busy || starve !== exp_starve || port_out !== exp_port) begin
                errors++;
                $display("FAIL random c%0d: gnt=%b busy=%b starve=%b port=%h required %b %b %b %h",
                         c, gnt, busy, starve, port_out, exp_gnt, exp_busy, exp_starve, exp_port);
            end

            for (int k = 0; k < N; k++) begin
                if (exp_gnt[k] || !req[k]) m_wait[k] = 0;
                else if (m_wait[k] < MW) m_wait[k]++;
            end
            if (exp_gnt != '0) begin
                m_rr     = (w + 1) % N;
                m_locked = 1'b0;
            end else if (!m_locked && w >= 0 && !flush) begin
                m_locked = 1'b1;
                m_owner  = w;
            end
            pend = pend & ~exp_gnt;
            tick();
        end
        req   = '0;
        flush = 1'b0;
        port_in = '0;
    endtask

    initial begin
        req     = '0;
        flush   = 1'b0;
        port_in = '0;
        for (int k = 0; k < N; k++) req_data[k] = '0;
        test_reset();
        test_lock();
        test_starve();
        test_flush_idle();
        test_flush_locked();
        test_reset_locked();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
